// File: rtl/alu_issue_seq_if.sv
// Command and response handshake bundle between a command source and the
// ALU issue sequencer. The master drives commands and consumes responses.
interface alu_issue_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [3:0] cmd_src;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [2:0] res_flags;

    modport master (
        output cmd_valid,
        output cmd_load,
        output cmd_op,
        output cmd_src,
        output res_ready,
        input  cmd_ready,
        input  res_valid,
        input  res_data,
        input  res_flags
    );

    modport slave (
        input  cmd_valid,
        input  cmd_load,
        input  cmd_op,
        input  cmd_src,
        input  res_ready,
        output cmd_ready,
        output res_valid,
        output res_data,
        output res_flags
    );
endinterface

// File: rtl/alu_issue_seq.sv
// Accumulator-style command sequencer for a 4-bit ALU.
// Commands arrive on the slave side of the bus and are either loaded straight
// into the accumulator or issued to the external ALU with registered operands.
// Results and flags are returned on a valid/ready response channel, and
// non-compare ALU results are written back so ops chain on the accumulator.
module alu_issue_seq #(
    parameter logic [3:0]  ACC_INIT = 4'h0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    alu_issue_seq_if.slave   s_bus,
    output logic [3:0]       o_alu_a,
    output logic [3:0]       o_alu_b,
    output logic [2:0]       o_alu_sel,
    input  logic [3:0]       i_alu_result,
    input  logic             i_alu_zero,
    input  logic             i_alu_overflow,
    input  logic             i_alu_carry,
    output logic [3:0]       o_acc,
    output logic [CNT_W-1:0] o_op_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic [3:0]       r_acc;
    logic [3:0]       w_acc_d;
    logic [3:0]       r_operand;
    logic [3:0]       w_operand_d;
    logic [2:0]       r_op;
    logic [2:0]       w_op_d;
    logic [3:0]       r_res_data;
    logic [3:0]       w_res_data_d;
    logic [2:0]       r_res_flags;
    logic [2:0]       w_res_flags_d;
    logic [CNT_W-1:0] r_op_count;
    logic [CNT_W-1:0] w_op_count_d;

    logic             w_idle;
    logic             w_resp;
    logic             w_accept;
    logic             w_res_fire;
    logic             w_op_arith;
    logic             w_op_cmp;
    logic             w_result_zero;

    assign w_idle     = (r_state == StIdle);
    assign w_resp     = (r_state == StResp);
    assign w_accept   = s_bus.cmd_valid & w_idle;
    assign w_res_fire = w_resp & s_bus.res_ready;

    // add/sub pass the ALU's own flags; compares do too but skip writeback
    assign w_op_arith    = (r_op == 3'b000) | (r_op == 3'b001);
    assign w_op_cmp      = (r_op[2:1] == 2'b11);
    assign w_result_zero = (i_alu_result == 4'h0);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_d     = r_state;
        w_acc_d       = r_acc;
        w_operand_d   = r_operand;
        w_op_d        = r_op;
        w_res_data_d  = r_res_data;
        w_res_flags_d = r_res_flags;
        w_op_count_d  = r_op_count;

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_operand_d = s_bus.cmd_src;
                    w_op_d      = s_bus.cmd_op;
                    if (s_bus.cmd_load) begin
                        w_acc_d       = s_bus.cmd_src;
                        w_res_data_d  = s_bus.cmd_src;
                        w_res_flags_d = {2'b00, (s_bus.cmd_src == 4'h0)};
                        w_state_d     = StResp;
                    end else begin
                        w_state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                w_res_data_d = i_alu_result;
                if (w_op_arith || w_op_cmp) begin
                    w_res_flags_d = {i_alu_carry, i_alu_overflow, i_alu_zero};
                end else begin
                    w_res_flags_d = {2'b00, w_result_zero};
                end
                if (!w_op_cmp) begin
                    w_acc_d = i_alu_result;
                end
                w_state_d = StResp;
            end
            StResp: begin
                if (w_res_fire) begin
                    w_op_count_d = r_op_count + CNT_W'(1);
                    w_state_d    = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Datapath registers: accumulator, latched command, response, counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc       <= ACC_INIT;
            r_operand   <= 4'h0;
            r_op        <= 3'b000;
            r_res_data  <= 4'h0;
            r_res_flags <= 3'b000;
            r_op_count  <= '0;
        end else begin
            r_acc       <= w_acc_d;
            r_operand   <= w_operand_d;
            r_op        <= w_op_d;
            r_res_data  <= w_res_data_d;
            r_res_flags <= w_res_flags_d;
            r_op_count  <= w_op_count_d;
        end
    end

    assign s_bus.cmd_ready = w_idle;
    assign s_bus.res_valid = w_resp;
    assign s_bus.res_data  = r_res_data;
    assign s_bus.res_flags = r_res_flags;

    // ALU inputs come only from registers so they are stable through ISSUE
    assign o_alu_a    = r_acc;
    assign o_alu_b    = r_operand;
    assign o_alu_sel  = r_op;
    assign o_acc      = r_acc;
    assign o_op_count = r_op_count;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: a behavioural 4-bit ALU, a directed
// vector table, reset-during-issue and backpressure sequences, randomized
// commands against a reference model, and a narrow-counter wrap instance.
module tb_alu_issue_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    alu_issue_seq_if u_bus ();
    alu_issue_seq_if u_bus2 ();

    logic [3:0] w_alu_a, w_alu_b, w_alu_result;
    logic [2:0] w_alu_sel;
    logic       w_alu_zero, w_alu_overflow, w_alu_carry;
    logic [3:0] w_acc;
    logic [7:0] w_op_count;

    logic [3:0] w2_alu_a, w2_alu_b, w2_acc;
    logic [2:0] w2_alu_sel;
    logic [1:0] w2_op_count;

    alu_issue_seq #(.ACC_INIT(4'h0), .CNT_W(8)) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .s_bus          (u_bus),
        .o_alu_a        (w_alu_a),
        .o_alu_b        (w_alu_b),
        .o_alu_sel      (w_alu_sel),
        .i_alu_result   (w_alu_result),
        .i_alu_zero     (w_alu_zero),
        .i_alu_overflow (w_alu_overflow),
        .i_alu_carry    (w_alu_carry),
        .o_acc          (w_acc),
        .o_op_count     (w_op_count)
    );

    // Loads never consult the ALU, so the narrow instance gets constant inputs
    alu_issue_seq #(.ACC_INIT(4'h0), .CNT_W(2)) u_dut2 (
        .i_clk          (clk),
        .i_rst          (rst),
        .s_bus          (u_bus2),
        .o_alu_a        (w2_alu_a),
        .o_alu_b        (w2_alu_b),
        .o_alu_sel      (w2_alu_sel),
        .i_alu_result   (4'h0),
        .i_alu_zero     (1'b0),
        .i_alu_overflow (1'b0),
        .i_alu_carry    (1'b0),
        .o_acc          (w2_acc),
        .o_op_count     (w2_op_count)
    );

    // Behavioural ALU: returns {carry, overflow, zero, result}
    function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] s);
        int         sa, sb, ua, ub, sum;
        logic [3:0] r;
        logic       c, v;
        ua  = int'(a);
        ub  = int'(b);
        sa  = a[3] ? ua - 16 : ua;
        sb  = b[3] ? ub - 16 : ub;
        // subtraction as a + ~b + 1 gives carry = no borrow
        sum = ua + (15 - ub) + 1;
        c   = (sum > 15);
        v   = ((sa - sb) > 7) || ((sa - sb) < -8);
        r   = 4'(sum);
        case (s)
            3'd0: begin
                sum = ua + ub;
                c   = (sum > 15);
                v   = ((sa + sb) > 7) || ((sa + sb) < -8);
                r   = 4'(sum);
            end
            3'd1: r = 4'(sum);
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = (sa < sb) ? 4'd1 : 4'd0;
            default: r = (a == b) ? 4'd1 : 4'd0;
        endcase
        return {c, v, (r == 4'h0), r};
    endfunction

    always_comb begin
        {w_alu_carry, w_alu_overflow, w_alu_zero, w_alu_result} =
            alu_fn(w_alu_a, w_alu_b, w_alu_sel);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model state
    logic [3:0] m_acc;
    int         m_cnt;

    // Issue one command and retire its response after dly cycles of backpressure
    task automatic exec(input logic ld, input logic [2:0] op, input logic [3:0] src,
                        input int dly, input logic [3:0] e_data, input logic [2:0] e_flags,
                        input logic [3:0] e_acc, input logic [3:0] a_prev, input int e_cnt);
        int t;
        int lat;
        u_bus.cmd_valid = 1'b1;
        u_bus.cmd_load  = ld;
        u_bus.cmd_op    = op;
        u_bus.cmd_src   = src;
        t = 0;
        while (!u_bus.cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!u_bus.cmd_ready) chk("cmd_ready_timeout", 0, 1);
        @(negedge clk);
        u_bus.cmd_valid = 1'b0;
        u_bus.cmd_op    = ~op;
        u_bus.cmd_src   = ~src;
        lat = 1;
        if (!ld) begin
            chk("issue_alu_a", int'(w_alu_a), int'(a_prev));
            chk("issue_alu_b", int'(w_alu_b), int'(src));
            chk("issue_alu_sel", int'(w_alu_sel), int'(op));
            chk("issue_cmd_ready", int'(u_bus.cmd_ready), 0);
        end
        while (!u_bus.res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, ld ? 1 : 2);
        chk("res_data", int'(u_bus.res_data), int'(e_data));
        chk("res_flags", int'(u_bus.res_flags), int'(e_flags));
        chk("acc_resp", int'(w_acc), int'(e_acc));
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(u_bus.res_valid), 1);
            chk("hold_data", int'(u_bus.res_data), int'(e_data));
            chk("hold_flags", int'(u_bus.res_flags), int'(e_flags));
            chk("hold_cmd_ready", int'(u_bus.cmd_ready), 0);
            chk("hold_acc", int'(w_acc), int'(e_acc));
            chk("hold_count", int'(w_op_count), (e_cnt - 1) % 256);
        end
        u_bus.res_ready = 1'b1;
        @(negedge clk);
        u_bus.res_ready = 1'b0;
        chk("post_res_valid", int'(u_bus.res_valid), 0);
        chk("post_cmd_ready", int'(u_bus.cmd_ready), 1);
        chk("post_acc", int'(w_acc), int'(e_acc));
        chk("post_count", int'(w_op_count), e_cnt % 256);
    endtask

    // Reference expectations derived from the command semantics
    task automatic run_model(input logic ld, input logic [2:0] op, input logic [3:0] src,
                             input int dly);
        logic [6:0] f;
        logic [3:0] d;
        logic [2:0] fl;
        logic [3:0] prev;
        prev = m_acc;
        if (ld) begin
            d     = src;
            fl    = {2'b00, (src == 4'h0)};
            m_acc = src;
        end else begin
            f  = alu_fn(m_acc, src, op);
            d  = f[3:0];
            fl = (op == 3'd0 || op == 3'd1 || op >= 3'd6) ? f[6:4] : {2'b00, (d == 4'h0)};
            if (op < 3'd6) m_acc = d;
        end
        m_cnt++;
        exec(ld, op, src, dly, d, fl, m_acc, prev, m_cnt);
    endtask

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [3:0] src;
        logic [3:0] e_data;
        logic [2:0] e_flags;
        logic [3:0] e_acc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{ld: 1'b1, op: 3'd0, src: 4'd5, e_data: 4'd5, e_flags: 3'b000, e_acc: 4'd5};
        vecs[1] = '{ld: 1'b0, op: 3'd0, src: 4'd3, e_data: 4'd8, e_flags: 3'b010, e_acc: 4'd8};
        vecs[2] = '{ld: 1'b0, op: 3'd1, src: 4'd1, e_data: 4'd7, e_flags: 3'b110, e_acc: 4'd7};
        vecs[3] = '{ld: 1'b0, op: 3'd5, src: 4'd7, e_data: 4'd0, e_flags: 3'b001, e_acc: 4'd0};
        vecs[4] = '{ld: 1'b1, op: 3'd7, src: 4'd2, e_data: 4'd2, e_flags: 3'b000, e_acc: 4'd2};
        vecs[5] = '{ld: 1'b0, op: 3'd6, src: 4'd3, e_data: 4'd1, e_flags: 3'b000, e_acc: 4'd2};
        vecs[6] = '{ld: 1'b0, op: 3'd7, src: 4'd2, e_data: 4'd1, e_flags: 3'b100, e_acc: 4'd2};

        rst              = 1'b1;
        u_bus.cmd_valid  = 1'b0;
        u_bus.cmd_load   = 1'b0;
        u_bus.cmd_op     = 3'd0;
        u_bus.cmd_src    = 4'd0;
        u_bus.res_ready  = 1'b0;
        u_bus2.cmd_valid = 1'b0;
        u_bus2.cmd_load  = 1'b1;
        u_bus2.cmd_op    = 3'd0;
        u_bus2.cmd_src   = 4'd0;
        u_bus2.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_cmd_ready", int'(u_bus.cmd_ready), 1);
        chk("rst_res_valid", int'(u_bus.res_valid), 0);
        chk("rst_res_data", int'(u_bus.res_data), 0);
        chk("rst_res_flags", int'(u_bus.res_flags), 0);
        chk("rst_acc", int'(w_acc), 0);
        chk("rst_op_count", int'(w_op_count), 0);
        chk("rst_alu_b", int'(w_alu_b), 0);
        chk("rst_alu_sel", int'(w_alu_sel), 0);

        // Directed table; acc before each entry comes from the previous row
        m_acc = 4'h0;
        m_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            m_cnt++;
            exec(vecs[i].ld, vecs[i].op, vecs[i].src, (i == 1) ? 5 : 0, vecs[i].e_data,
                 vecs[i].e_flags, vecs[i].e_acc, m_acc, m_cnt);
            m_acc = vecs[i].e_acc;
        end

        // Reset while an add is in ISSUE: nothing may come out of it
        run_model(1'b1, 3'd0, 4'd1, 0);
        u_bus.cmd_valid = 1'b1;
        u_bus.cmd_load  = 1'b0;
        u_bus.cmd_op    = 3'd0;
        u_bus.cmd_src   = 4'd4;
        @(negedge clk);
        u_bus.cmd_valid = 1'b0;
        chk("pre_rst_issue_alu_b", int'(w_alu_b), 4);
        rst = 1'b1;
        u_bus.res_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_cmd_ready", int'(u_bus.cmd_ready), 1);
        chk("mid_rst_res_valid", int'(u_bus.res_valid), 0);
        chk("mid_rst_acc", int'(w_acc), 0);
        chk("mid_rst_op_count", int'(w_op_count), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_resp", int'(u_bus.res_valid), 0);
            chk("mid_rst_count_hold", int'(w_op_count), 0);
        end
        u_bus.res_ready = 1'b0;
        m_acc = 4'h0;
        m_cnt = 0;

        // Randomized command stream against the reference model
        for (int i = 0; i < 60; i++) begin
            run_model(($urandom_range(3) == 0), 3'($urandom_range(7)),
                      4'($urandom_range(15)), $urandom_range(3));
        end

        // Narrow counter: cmd_valid held high, only taken in IDLE
        u_bus2.cmd_valid = 1'b1;
        u_bus2.res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            u_bus2.cmd_src = 4'(i + 1);
            u_bus2.cmd_op  = 3'(i);
            chk("w_idle_ready", int'(u_bus2.cmd_ready), 1);
            @(negedge clk);
            chk("w_resp_valid", int'(u_bus2.res_valid), 1);
            chk("w_resp_cmd_ready", int'(u_bus2.cmd_ready), 0);
            chk("w_resp_data", int'(u_bus2.res_data), i + 1);
            chk("w_alu_b_latched", int'(w2_alu_b), i + 1);
            chk("w_alu_sel_latched", int'(w2_alu_sel), i);
            u_bus2.cmd_src = 4'hF;
            @(negedge clk);
            chk("w_acc_kept", int'(w2_acc), i + 1);
            chk("w_alu_a_acc", int'(w2_alu_a), i + 1);
            chk("w_op_count", int'(w2_op_count), (i + 1) % 4);
        end
        u_bus2.cmd_valid = 1'b0;
        u_bus2.res_ready = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
